mem_port_arbiter: RTL and testbench

- Arbitrates the single-port synchronous RAM between two requesters: the CPU datapath (MAR/MDR Read/Write path) and the debug/program loader port.
- Sits between DataPath and the memory block in the MiniSRC top level.
- Sequences each access as a multi-cycle transaction with a req/done handshake.
- Two-way round-robin arbitration guarantees neither requester starves.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_arb_rr2.sv | 16 +
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the MiniSRC memory-port arbiter.
// ADDR_W/DATA_W defaults live here so MiniSRC and the RAM can reuse them.
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWDefault = 9;
  localparam int unsigned DataWDefault = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic OwnerCpu = 1'b0;
  localparam logic OwnerDbg = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and status signals of the memory-port arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_done, dbg_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_done, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  owner, busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-requester round-robin pick; purely combinational, pointer held by the parent.
module mem_port_arbiter_arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_cpu_i,
  input  logic req_dbg_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic gnt_o
);

  assign valid_o = req_cpu_i | req_dbg_i;
  // The pointer only matters under contention; a lone requester always wins.
  assign gnt_o   = (req_cpu_i & req_dbg_i) ? ptr_i : (req_dbg_i ? OwnerDbg : OwnerCpu);

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/debug arbiter for the single-port RAM: IDLE -> ISSUE -> (WAIT) -> DONE per access.
// Optional macro ARB_CONTENTION_CNT_EN adds a saturating contention counter output.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned RD_LAT = 1
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_CONTENTION_CNT_EN
  ,
  output logic [15:0] contention_cnt
`endif
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              gnt_valid;
  logic              gnt;

  mem_port_arbiter_arb_rr2 u_arb (
    .req_cpu_i (bus.cpu_req),
    .req_dbg_i (bus.dbg_req),
    .ptr_i     (ptr_q),
    .valid_o   (gnt_valid),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt;
          we_d    = (gnt == OwnerDbg) ? bus.dbg_we    : bus.cpu_we;
          addr_d  = (gnt == OwnerDbg) ? bus.dbg_addr  : bus.cpu_addr;
          wdata_d = (gnt == OwnerDbg) ? bus.dbg_wdata : bus.cpu_wdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          cnt_d   = CntW'(RD_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (owner_q == OwnerDbg) dbg_rdata_d = bus.mem_rdata;
          else                     cpu_rdata_d = bus.mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        ptr_d   = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= OwnerCpu;
      owner_q     <= OwnerCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Reset overrides strobes and done so an aborted transaction leaves no trace.
  assign bus.mem_we    = (state_q == StIssue) && we_q && !reset;
  assign bus.mem_re    = (state_q == StIssue) && !we_q && !reset;
  assign bus.cpu_done  = (state_q == StDone) && (owner_q == OwnerCpu) && !reset;
  assign bus.dbg_done  = (state_q == StDone) && (owner_q == OwnerDbg) && !reset;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != StIdle);

`ifdef ARB_CONTENTION_CNT_EN
  logic [15:0] contention_q, contention_d;

  always_comb begin
    contention_d = contention_q;
    if ((state_q == StIdle) && bus.cpu_req && bus.dbg_req && (contention_q != 16'hFFFF)) begin
      contention_d = contention_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) contention_q <= '0;
    else       contention_q <= contention_d;
  end

  assign contention_cnt = contention_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u1 uses RD_LAT=1, u3 uses RD_LAT=3; each has its own RAM model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) b3 ();

`ifdef ARB_CONTENTION_CNT_EN
  logic [15:0] cc1, cc3;
`endif

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) u1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
`ifdef ARB_CONTENTION_CNT_EN
    ,
    .contention_cnt (cc1)
`endif
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) u3 (
    .clock (clock),
    .reset (reset),
    .bus   (b3)
`ifdef ARB_CONTENTION_CNT_EN
    ,
    .contention_cnt (cc3)
`endif
  );

  always #5 clock = ~clock;

  // RAM models; outside the valid read slot they drive a junk pattern.
  logic        pl_we = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] ram1 [512];
  logic [31:0] ram3 [512];
  logic        p1_v = 1'b0;
  logic [31:0] p1_d;
  logic [2:0]  p3_v = '0;
  logic [31:0] p3_d [3];

  always @(posedge clock) begin
    if (pl_we) ram1[pl_addr] <= pl_data;
    else if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_wdata;
    p1_v <= b1.mem_re;
    p1_d <= ram1[b1.mem_addr];
  end
  assign b1.mem_rdata = p1_v ? p1_d : 32'hBAD0BAD0;

  always @(posedge clock) begin
    if (pl_we) ram3[pl_addr] <= pl_data;
    else if (b3.mem_we) ram3[b3.mem_addr] <= b3.mem_wdata;
    p3_v    <= {p3_v[1:0], b3.mem_re};
    p3_d[0] <= ram3[b3.mem_addr];
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end
  assign b3.mem_rdata = p3_v[2] ? p3_d[2] : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dbg_req = 1'b0; b1.dbg_we = 1'b0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dbg_req = 1'b0; b3.dbg_we = 1'b0; b3.dbg_addr = '0; b3.dbg_wdata = '0;

    // Preload both RAMs while the arbiters are held in reset
    tick();
    pl_we = 1'b1; pl_addr = 9'h010; pl_data = 32'hDEADBEEF; tick();
    pl_addr = 9'h040; pl_data = 32'hCAFEF00D; tick();
    pl_addr = 9'h077; pl_data = 32'h11112222; tick();
    pl_we = 1'b0; tick();

    // Reset values
    chk("rst_busy", 32'(b1.busy), 32'd0);
    chk("rst_owner", 32'(b1.owner), 32'(OwnerCpu));
    chk("rst_cpu_done", 32'(b1.cpu_done), 32'd0);
    chk("rst_dbg_done", 32'(b1.dbg_done), 32'd0);
    chk("rst_mem_we", 32'(b1.mem_we), 32'd0);
    chk("rst_mem_re", 32'(b1.mem_re), 32'd0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", b1.dbg_rdata, 32'd0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
    chk("rst_mem_wdata", b1.mem_wdata, 32'd0);
`ifdef ARB_CONTENTION_CNT_EN
    chk("rst_contention", 32'(cc1), 32'd0);
`endif
    reset = 1'b0;

    // Single CPU read of 0x010, RD_LAT=1
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 9'h010;
    chk("rd_c0_busy", 32'(b1.busy), 32'd0);
    tick();
    chk("rd_c1_mem_re", 32'(b1.mem_re), 32'd1);
    chk("rd_c1_mem_we", 32'(b1.mem_we), 32'd0);
    chk("rd_c1_mem_addr", 32'(b1.mem_addr), 32'h010);
    chk("rd_c1_busy", 32'(b1.busy), 32'd1);
    b1.cpu_req = 1'b0;
    tick();
    chk("rd_c2_mem_re", 32'(b1.mem_re), 32'd0);
    chk("rd_c2_cpu_done", 32'(b1.cpu_done), 32'd0);
    chk("rd_c2_dbg_done", 32'(b1.dbg_done), 32'd0);
    tick();
    chk("rd_c3_cpu_done", 32'(b1.cpu_done), 32'd1);
    chk("rd_c3_cpu_rdata", b1.cpu_rdata, 32'hDEADBEEF);
    chk("rd_c3_dbg_done", 32'(b1.dbg_done), 32'd0);
    tick();
    chk("rd_c4_cpu_done", 32'(b1.cpu_done), 32'd0);
    chk("rd_c4_busy", 32'(b1.busy), 32'd0);
    chk("rd_c4_rdata_held", b1.cpu_rdata, 32'hDEADBEEF);

    // Debug write 0x1FF, then CPU read-back
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 9'h1FF; b1.dbg_wdata = 32'h12345678;
    tick();
    chk("wr_c1_mem_we", 32'(b1.mem_we), 32'd1);
    chk("wr_c1_mem_re", 32'(b1.mem_re), 32'd0);
    chk("wr_c1_mem_addr", 32'(b1.mem_addr), 32'h1FF);
    chk("wr_c1_mem_wdata", b1.mem_wdata, 32'h12345678);
    chk("wr_c1_owner", 32'(b1.owner), 32'(OwnerDbg));
    b1.dbg_req = 1'b0;
    tick();
    chk("wr_c2_dbg_done", 32'(b1.dbg_done), 32'd1);
    chk("wr_c2_cpu_done", 32'(b1.cpu_done), 32'd0);
    chk("wr_c2_mem_we", 32'(b1.mem_we), 32'd0);
    tick();
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 9'h1FF;
    tick();
    b1.cpu_req = 1'b0;
    tick();
    tick();
    chk("rb_cpu_done", 32'(b1.cpu_done), 32'd1);
    chk("rb_cpu_rdata", b1.cpu_rdata, 32'h12345678);
    tick();

    // Reset pulse, then both requesters held for four transactions
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_rst_owner", 32'(b1.owner), 32'(OwnerCpu));
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 9'h010;
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 9'h020; b1.dbg_wdata = 32'hA5A50001;
    tick();
    chk("rr_g0_owner", 32'(b1.owner), 32'(OwnerCpu));
    chk("rr_g0_mem_re", 32'(b1.mem_re), 32'd1);
    tick(); tick();
    chk("rr_g0_cpu_done", 32'(b1.cpu_done), 32'd1);
    tick(); tick();
    chk("rr_g1_owner", 32'(b1.owner), 32'(OwnerDbg));
    chk("rr_g1_mem_we", 32'(b1.mem_we), 32'd1);
    tick();
    chk("rr_g1_dbg_done", 32'(b1.dbg_done), 32'd1);
    tick(); tick();
    chk("rr_g2_owner", 32'(b1.owner), 32'(OwnerCpu));
    tick(); tick();
    chk("rr_g2_cpu_done", 32'(b1.cpu_done), 32'd1);
    tick(); tick();
    chk("rr_g3_owner", 32'(b1.owner), 32'(OwnerDbg));
    tick();
    chk("rr_g3_dbg_done", 32'(b1.dbg_done), 32'd1);
    tick();
    b1.cpu_req = 1'b0; b1.dbg_req = 1'b0;
    tick();
    chk("rr_end_busy", 32'(b1.busy), 32'd0);
`ifdef ARB_CONTENTION_CNT_EN
    chk("rr_contention", 32'(cc1), 32'd4);
`endif

    // RD_LAT=3 CPU read; address change during WAIT must not reach the RAM
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 9'h040;
    tick();
    chk("l3_c1_mem_re", 32'(b3.mem_re), 32'd1);
    chk("l3_c1_mem_addr", 32'(b3.mem_addr), 32'h040);
    b3.cpu_req = 1'b0; b3.cpu_addr = 9'h155;
    tick();
    chk("l3_c2_mem_addr", 32'(b3.mem_addr), 32'h040);
    chk("l3_c2_mem_re", 32'(b3.mem_re), 32'd0);
    tick();
    chk("l3_c3_mem_addr", 32'(b3.mem_addr), 32'h040);
    chk("l3_c3_cpu_done", 32'(b3.cpu_done), 32'd0);
    tick();
    chk("l3_c4_cpu_done", 32'(b3.cpu_done), 32'd0);
    chk("l3_c4_mem_rdata", b3.mem_rdata, 32'hCAFEF00D);
    tick();
    chk("l3_c5_cpu_done", 32'(b3.cpu_done), 32'd1);
    chk("l3_c5_cpu_rdata", b3.cpu_rdata, 32'hCAFEF00D);
    tick();
    chk("l3_c6_busy", 32'(b3.busy), 32'd0);

    // Reset during u3 dbg read WAIT, coinciding with u1 dbg write ISSUE
    b3.dbg_req = 1'b1; b3.dbg_we = 1'b0; b3.dbg_addr = 9'h077;
    tick();
    b3.dbg_req = 1'b0;
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 9'h0AA; b1.dbg_wdata = 32'h55AA55AA;
    tick();
    chk("ab_u1_issue_we", 32'(b1.mem_we), 32'd1);
    chk("ab_u3_busy", 32'(b3.busy), 32'd1);
    b1.dbg_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("ab_u1_we_suppressed", 32'(b1.mem_we), 32'd0);
    tick();
    chk("ab_u3_busy_after", 32'(b3.busy), 32'd0);
    chk("ab_u3_dbg_done", 32'(b3.dbg_done), 32'd0);
    chk("ab_u3_dbg_rdata", b3.dbg_rdata, 32'd0);
    chk("ab_u1_busy_after", 32'(b1.busy), 32'd0);
    chk("ab_u1_dbg_done", 32'(b1.dbg_done), 32'd0);
    reset = 1'b0;
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 9'h040;
    b3.dbg_req = 1'b1; b3.dbg_we = 1'b0; b3.dbg_addr = 9'h077;
    tick();
    chk("ab_first_owner", 32'(b3.owner), 32'(OwnerCpu));
    chk("ab_first_addr", 32'(b3.mem_addr), 32'h040);
    chk("ab_first_re", 32'(b3.mem_re), 32'd1);
    b3.cpu_req = 1'b0; b3.dbg_req = 1'b0;
    tick(); tick(); tick();
    chk("ab_no_dbg_done", 32'(b3.dbg_done), 32'd0);
    tick();
    chk("ab_cpu_done", 32'(b3.cpu_done), 32'd1);
    chk("ab_cpu_rdata", b3.cpu_rdata, 32'hCAFEF00D);
    tick();

    // One-cycle cpu_req while u1 is busy with a dbg write is dropped
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 9'h033; b1.dbg_wdata = 32'h00C0FFEE;
    tick();
    chk("pl_c1_mem_we", 32'(b1.mem_we), 32'd1);
    b1.dbg_req = 1'b0;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 9'h010;
    tick();
    chk("pl_c2_dbg_done", 32'(b1.dbg_done), 32'd1);
    chk("pl_c2_cpu_done", 32'(b1.cpu_done), 32'd0);
    b1.cpu_req = 1'b0;
    tick();
    chk("pl_c3_busy", 32'(b1.busy), 32'd0);
    chk("pl_c3_cpu_done", 32'(b1.cpu_done), 32'd0);
    tick();
    chk("pl_c4_busy", 32'(b1.busy), 32'd0);
    chk("pl_c4_mem_re", 32'(b1.mem_re), 32'd0);
    tick();
    chk("pl_c5_cpu_done", 32'(b1.cpu_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
